// File: rtl/mux_scan_sampler.sv
// Scan controller for an 8:1 mux: steps the select lines through NUM_CH channels,
// samples the mux output after a settle delay and hands off each frame over valid/ready.
module mux_scan_sampler #(
  parameter int NUM_CH     = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              mux_y,
  output logic [3:0]        mux_sel,
  output logic              busy,
  output logic [NUM_CH-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              overrun,
  output logic [1:0]        o_dbg_state
);

  localparam int              CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [2:0]      CH_LAST  = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_ch;
  logic [2:0]          w_ch_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [NUM_CH-1:0]   r_frame;
  logic [NUM_CH-1:0]   w_frame_nxt;
  logic [NUM_CH-1:0]   w_frame_done;
  logic                w_frame_end;
  logic [NUM_CH-1:0]   r_data;
  logic                r_valid;
  logic                r_ovr;

  // Handshake: data_out is transferred on any edge where data_valid && data_ready;
  // data_valid stays high and data_out stable until that transfer happens.

  // Frame with the current channel's sample merged in, used both for the
  // frame register update and for the output load at frame completion.
  always_comb begin
    w_frame_done = r_frame;
    for (int k = 0; k < NUM_CH; k++) begin
      if (r_ch == 3'(k)) w_frame_done[k] = mux_y;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    w_frame_nxt = r_frame;
    w_frame_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SETTLE;
          w_ch_nxt    = 3'd0;
          w_cnt_nxt   = '0;
          w_frame_nxt = '0;
        end
      end
      S_SETTLE: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_SAMPLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SAMPLE: begin
        w_frame_nxt = w_frame_done;
        w_cnt_nxt   = '0;
        if (r_ch == CH_LAST) begin
          w_frame_end = 1'b1;
          w_ch_nxt    = 3'd0;
          if (continuous) begin
            w_state_nxt = S_SETTLE;
            w_frame_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_ch_nxt    = r_ch + 3'd1;
          w_state_nxt = S_SETTLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ch_nxt    = 3'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= 3'd0;
      r_cnt   <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  // A frame arriving while the previous one is still pending is dropped, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_frame_end) begin
        if (!r_valid || data_ready) begin
          r_data  <= w_frame_done;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  // r_ch is forced to 0 whenever the FSM returns to idle, so the select is purely registered.
  assign mux_sel     = {1'b0, r_ch};
  assign busy        = (r_state != S_IDLE);
  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign overrun     = r_ovr;
  assign o_dbg_state = r_state;

endmodule
